// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encoding for the CPU run controller.
// The optional stall counter is enabled by defining CPU_RUN_CTRL_STALL_CNT_EN.
package cpu_run_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_run_ctrl_hart_mon.sv
// Per-hart halt monitor: sticky halt flag plus the a0 value captured on the first halt.
// The halted/code outputs also reflect a halt arriving this cycle so the controller can finish without delay.
module cpu_run_ctrl_hart_mon
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  halt,
  input  logic [DATA_WIDTH-1:0] a0,
  output logic                  halted,
  output logic                  code_nz,
  output logic [DATA_WIDTH-1:0] code
);

  logic                  halt_q, halt_d;
  logic [DATA_WIDTH-1:0] code_q, code_d;
  logic                  take_s;

  // Next-state for the sticky flag and captured exit code
  always_comb begin
    take_s = en & halt & ~halt_q;
    if (clr) begin
      halt_d = 1'b0;
      code_d = '0;
    end else if (take_s) begin
      halt_d = 1'b1;
      code_d = a0;
    end else begin
      halt_d = halt_q;
      code_d = code_q;
    end
  end

  // Flag and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
      code_q <= '0;
    end else begin
      halt_q <= halt_d;
      code_q <= code_d;
    end
  end

  assign halted  = halt_q | (en & halt);
  assign code    = halt_q ? code_q : a0;
  assign code_nz = halted & (code != '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences core reset, counts RUN cycles/commits, ends on all-halt or watchdog.
// Defining CPU_RUN_CTRL_STALL_CNT_EN adds the o_stall_cnt output (commit-free RUN cycles).
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int NUM_HARTS      = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                            i_sys_clk,
  input  logic                            i_sys_rst_n,
  input  logic                            i_run_en,
  input  logic [NUM_HARTS-1:0]            i_hart_commit,
  input  logic [NUM_HARTS-1:0]            i_hart_halt,
  input  logic [NUM_HARTS*DATA_WIDTH-1:0] i_hart_a0,
  output logic                            o_cpu_rst_n,
  output logic [STATE_W-1:0]              o_state,
  output logic [CNT_WIDTH-1:0]            o_cycle_cnt,
  output logic [CNT_WIDTH-1:0]            o_inst_cnt,
  output logic                            o_done,
  output logic                            o_pass,
  output logic                            o_timeout,
  output logic [DATA_WIDTH-1:0]           o_exit_code
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]            o_stall_cnt
`endif
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PCW = $clog2(NUM_HARTS + 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PCW-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  state_e                state_q, state_d;
  logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [WDW-1:0]        wdog_q, wdog_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d, inst_q, inst_d;
  logic                  done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic [DATA_WIDTH-1:0] exit_q, exit_d;
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
`endif

  logic [NUM_HARTS-1:0]  halted_s, nz_s;
  logic [DATA_WIDTH-1:0] code_s [NUM_HARTS];
  logic [PCW-1:0]        commit_cnt_s;
  logic [DATA_WIDTH-1:0] exit_sel_s;
  logic                  start_s, in_run_s, active_s, commit_any_s, halt_done_s, wd_fire_s;

  assign start_s  = (state_q == ST_IDLE) & i_run_en;
  assign in_run_s = (state_q == ST_RUN);
  assign active_s = in_run_s & i_run_en;

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    cpu_run_ctrl_hart_mon #(.DATA_WIDTH(DATA_WIDTH)) u_mon (
      .clk    (i_sys_clk),
      .rst_n  (i_sys_rst_n),
      .clr    (start_s),
      .en     (in_run_s),
      .halt   (i_hart_halt[g]),
      .a0     (i_hart_a0[g*DATA_WIDTH +: DATA_WIDTH]),
      .halted (halted_s[g]),
      .code_nz(nz_s[g]),
      .code   (code_s[g])
    );
  end

  // Commit popcount and lowest-index nonzero exit-code select
  always_comb begin
    commit_cnt_s = '0;
    exit_sel_s   = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      commit_cnt_s = commit_cnt_s + PCW'(i_hart_commit[h]);
    end
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (nz_s[h]) begin
        exit_sel_s = code_s[h];
      end else begin
        exit_sel_s = exit_sel_s;
      end
    end
    commit_any_s = |i_hart_commit;
    halt_done_s  = in_run_s & (&halted_s);
    wd_fire_s    = active_s & ~commit_any_s & (wdog_q == WD_LAST);
  end

  // FSM next-state, counters and completion status
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    wdog_d    = wdog_q;
    cycle_d   = cycle_q;
    inst_d    = inst_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    exit_d    = exit_q;
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
    stall_d   = stall_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_run_en) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          wdog_d    = '0;
          cycle_d   = '0;
          inst_d    = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          exit_d    = '0;
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
          stall_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESET: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        state_d   = (rst_cnt_q == RST_LAST) ? ST_RUN : ST_RESET;
      end
      ST_RUN: begin
        if (active_s) begin
          cycle_d = sat_add(cycle_q, PCW'(1'b1));
          inst_d  = sat_add(inst_q, commit_cnt_s);
          wdog_d  = commit_any_s ? '0 : wdog_q + 1'b1;
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
          stall_d = commit_any_s ? stall_q : sat_add(stall_q, PCW'(1'b1));
`endif
        end else begin
          cycle_d = cycle_q;
          inst_d  = inst_q;
          wdog_d  = wdog_q;
        end
        // A halt completion in the same cycle as the watchdog takes priority
        if (halt_done_s) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          pass_d    = ~(|nz_s);
          timeout_d = 1'b0;
          exit_d    = exit_sel_s;
        end else if (wd_fire_s) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          exit_d    = exit_sel_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = i_run_en ? ST_DONE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cpu_rst_n_d = (state_d == ST_RUN);
  end

  // State and output registers
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      wdog_q      <= '0;
      cycle_q     <= '0;
      inst_q      <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_q      <= '0;
      cpu_rst_n_q <= 1'b0;
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      wdog_q      <= wdog_d;
      cycle_q     <= cycle_d;
      inst_q      <= inst_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      exit_q      <= exit_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign o_cpu_rst_n = cpu_rst_n_q;
  assign o_state     = state_q;
  assign o_cycle_cnt = cycle_q;
  assign o_inst_cnt  = inst_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_timeout   = timeout_q;
  assign o_exit_code = exit_q;
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: expected run results are queued as each run is launched
// and compared when o_done rises; other points are checked inline.
module tb_cpu_run_ctrl;

  localparam int NH = 2;
  localparam int DW = 32;
  localparam int CW = 6;
  localparam int RC = 16;
  localparam int TO = 8;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             run_en = 1'b0;
  logic [NH-1:0]    commit = '0;
  logic [NH-1:0]    halt   = '0;
  logic [NH*DW-1:0] a0     = '0;
  logic             cpu_rst_n;
  logic [1:0]       state;
  logic [CW-1:0]    cyc, inst;
  logic             done, pass, tmo;
  logic [DW-1:0]    exit_code;
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
  logic [CW-1:0]    stall;
`endif

  typedef struct {
    logic          pass;
    logic          tmo;
    logic [DW-1:0] ec;
    logic [CW-1:0] inst;
    logic [CW-1:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cpu_run_ctrl #(
    .NUM_HARTS(NH), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
    .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_run_en     (run_en),
    .i_hart_commit(commit),
    .i_hart_halt  (halt),
    .i_hart_a0    (a0),
    .o_cpu_rst_n  (cpu_rst_n),
    .o_state      (state),
    .o_cycle_cnt  (cyc),
    .o_inst_cnt   (inst),
    .o_done       (done),
    .o_pass       (pass),
    .o_timeout    (tmo),
    .o_exit_code  (exit_code)
`ifdef CPU_RUN_CTRL_STALL_CNT_EN
    ,
    .o_stall_cnt  (stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a0(input int h, input logic [DW-1:0] v);
    a0[h*DW +: DW] = v;
  endtask

  task automatic push_exp(input logic p, input logic t, input logic [DW-1:0] ec,
                          input logic [CW-1:0] i, input logic [CW-1:0] c);
    exp_t e;
    e.pass = p; e.tmo = t; e.ec = ec; e.inst = i; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_state(input logic [1:0] st, input int bound, input string tag);
    int n = 0;
    while (state !== st && n < bound) begin
      tick();
      n++;
    end
    chk(tag, state, st);
  endtask

  task automatic wait_done_check(input string tag);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_pass"}, pass, e.pass);
      chk({tag, "_timeout"}, tmo, e.tmo);
      chk({tag, "_exit"}, exit_code, e.ec);
      chk({tag, "_inst"}, inst, e.inst);
      chk({tag, "_cycle"}, cyc, e.cyc);
    end else begin
      chk({tag, "_sb_empty"}, sb.size(), 1);
    end
  endtask

  task automatic restart(input string tag);
    run_en = 1'b0;
    tick();
    run_en = 1'b1;
    wait_state(2'd2, 40, {tag, "_to_run"});
  endtask

  initial begin
    int n;
    int low;
    repeat (2) tick();
    chk("rst_state", state, 2'd0);
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_cycle", cyc, '0);
    chk("rst_inst", inst, '0);
    chk("rst_status", {done, pass, tmo}, 3'b000);
    chk("rst_exit", exit_code, '0);

    // Core reset sequencing
    rst_n  = 1'b1;
    run_en = 1'b1;
    tick();
    n = 0;
    low = 0;
    while (state === 2'd1 && n < 100) begin
      if (cpu_rst_n === 1'b0) low++;
      n++;
      tick();
    end
    chk("reset_len", n, RC);
    chk("reset_low", low, RC);
    chk("run_state", state, 2'd2);
    chk("run_cpu_rst_n", cpu_rst_n, 1'b1);
    chk("run_cycle0", cyc, '0);

    // Ten commits then both harts halt with a0=0
    push_exp(1'b1, 1'b0, 32'd0, 6'd10, 6'd11);
    commit = 2'b01;
    repeat (10) tick();
    commit = 2'b00;
    halt   = 2'b11;
    tick();
    halt   = 2'b00;
    wait_done_check("a");
    chk("a_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("a_state", state, 2'd3);
    repeat (3) tick();
    chk("a_hold_cycle", cyc, 6'd11);
    run_en = 1'b0;
    tick();
    chk("idle_state", state, 2'd0);
    chk("idle_done_held", done, 1'b1);
    chk("idle_pass_held", pass, 1'b1);
    chk("idle_inst_held", inst, 6'd10);

    // Staggered halts; hart0 a0 change after capture is ignored
    run_en = 1'b1;
    tick();
    chk("b_reset_state", state, 2'd1);
    chk("b_reset_clears", {done, pass, tmo}, 3'b000);
    wait_state(2'd2, 40, "b_to_run");
    push_exp(1'b0, 1'b0, 32'd3, 6'd6, 6'd6);
    commit = 2'b01;
    halt   = 2'b01;
    set_a0(0, 32'd0);
    tick();
    halt   = 2'b00;
    commit = 2'b10;
    set_a0(0, 32'd7);
    repeat (4) tick();
    chk("b_not_done_early", done, 1'b0);
    halt = 2'b10;
    set_a0(1, 32'd3);
    tick();
    halt   = 2'b00;
    commit = 2'b00;
    wait_done_check("b");
    a0 = '0;

    // Watchdog timeout with hart1 halted on code 5
    restart("c");
    push_exp(1'b0, 1'b1, 32'd5, 6'd0, 6'd8);
    halt = 2'b10;
    set_a0(1, 32'd5);
    tick();
    halt = 2'b00;
    set_a0(1, 32'd0);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("c_timeout_len", n, TO);
    wait_done_check("c");

    // Halt and timeout in the same cycle
    restart("d");
    push_exp(1'b1, 1'b0, 32'd0, 6'd0, 6'd8);
    repeat (7) tick();
    chk("d_not_done_early", done, 1'b0);
    halt = 2'b11;
    tick();
    halt = 2'b00;
    wait_done_check("d");

    // Pause freezes counters and watchdog
    restart("e");
    push_exp(1'b0, 1'b1, 32'd0, 6'd4, 6'd10);
    commit = 2'b11;
    repeat (2) tick();
    commit = 2'b00;
    repeat (3) tick();
    run_en = 1'b0;
    commit = 2'b11;
    repeat (4) tick();
    chk("e_pause_cycle", cyc, 6'd5);
    chk("e_pause_inst", inst, 6'd4);
    chk("e_pause_state", state, 2'd2);
    chk("e_pause_cpu_rst_n", cpu_rst_n, 1'b1);
    commit = 2'b00;
    run_en = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("e_resume_len", n, 5);
    wait_done_check("e");

    // Counter saturation, then asynchronous reset mid-run
    restart("f");
    commit = 2'b11;
    repeat (40) tick();
    chk("f_inst_sat", inst, 6'd63);
    chk("f_cycle_40", cyc, 6'd40);
    repeat (30) tick();
    chk("f_cycle_sat", cyc, 6'd63);
    chk("f_inst_sat_hold", inst, 6'd63);
    #2 rst_n = 1'b0;
    #1;
    chk("g_async_state", state, 2'd0);
    chk("g_async_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("g_async_cycle", cyc, '0);
    chk("g_async_inst", inst, '0);
    chk("g_async_status", {done, pass, tmo}, 3'b000);
    commit = 2'b00;
    run_en = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
